// File: rtl/rr_sched8_pkg.sv
// Shared types and constants for the 8-source round-robin scheduler.
// Holds the FSM state encoding and a one-hot helper used by the arbiter.
package rr_sched8_pkg;

   localparam int N_SRC = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   function automatic logic [N_SRC-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      logic [N_SRC-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux8x1.sv
// Plain 8:1 single-bit multiplexer driving the shared serial line.
// Inputs a..h correspond to sources 0..7, select is {x2,x1,x0}.
module mux8x1 (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic e,
   input  logic f,
   input  logic g,
   input  logic h,
   input  logic x0,
   input  logic x1,
   input  logic x2,
   output logic y
);

   always_comb begin
      y = 1'b0;
      case ({x2, x1, x0})
         3'd0:    y = a;
         3'd1:    y = b;
         3'd2:    y = c;
         3'd3:    y = d;
         3'd4:    y = e;
         3'd5:    y = f;
         3'd6:    y = g;
         default: y = h;
      endcase
   end

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority search: first set request at or after ptr, wrapping 7->0.
// The current owner can be masked out so a preempt never re-picks it.
module rr_pick8
   import rr_sched8_pkg::*;
(
   input  logic [N_SRC-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             excl_en,
   input  logic [IDX_W-1:0] excl_idx,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N_SRC-1:0] cand;

   // Walk from farthest to nearest so the offset closest to ptr wins last.
   always_comb begin
      cand = req;
      if (excl_en) begin
         cand[excl_idx] = 1'b0;
      end
      found = 1'b0;
      idx   = ptr;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (cand[ptr + IDX_W'(k)]) begin
            found = 1'b1;
            idx   = ptr + IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/rr_sched8.sv
// Round-robin scheduler: fair, hold-bounded arbitration of 8 requesters
// onto one shared 8:1 bit-select path, with a registered one-hot grant.
module rr_sched8
   import rr_sched8_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] req,
   input  logic [N_SRC-1:0] din,
   output logic [N_SRC-1:0] gnt,
   output logic [IDX_W-1:0] sel,
   output logic             busy,
   output logic             out
);

   localparam logic [HOLD_W-1:0] MaxHold = HOLD_W'(MAX_HOLD);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   sel_q, sel_d;
   logic [N_SRC-1:0]   gnt_q, gnt_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic               pickFound;
   logic [IDX_W-1:0]   pickIdx;
   logic [IDX_W-1:0]   searchPtr;
   logic               inGrant;
   logic               muxY;

   // While granted, any hand-over searches from the slot after the owner,
   // which is exactly the pointer value the hand-over will commit.
   assign inGrant   = (state_q == ST_GRANT);
   assign searchPtr = inGrant ? (sel_q + 3'd1) : ptr_q;

   rr_pick8 u_pick (
      .req      (req),
      .ptr      (searchPtr),
      .excl_en  (inGrant),
      .excl_idx (sel_q),
      .found    (pickFound),
      .idx      (pickIdx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      hold_d  = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (pickFound) begin
               state_d = ST_GRANT;
               sel_d   = pickIdx;
               gnt_d   = idx2onehot(pickIdx);
               hold_d  = HOLD_W'(1);
            end
         end
         default: begin
            if (!req[sel_q] || ((hold_q == MaxHold) && |(req & ~gnt_q))) begin
               ptr_d = sel_q + 3'd1;
               if (pickFound) begin
                  sel_d  = pickIdx;
                  gnt_d  = idx2onehot(pickIdx);
                  hold_d = HOLD_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
                  hold_d  = '0;
               end
            end else if (hold_q < MaxHold) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
      end
   end

   mux8x1 u_mux (
      .a  (din[0]),
      .b  (din[1]),
      .c  (din[2]),
      .d  (din[3]),
      .e  (din[4]),
      .f  (din[5]),
      .g  (din[6]),
      .h  (din[7]),
      .x0 (sel_q[0]),
      .x1 (sel_q[1]),
      .x2 (sel_q[2]),
      .y  (muxY)
   );

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = inGrant;
   assign out  = inGrant & muxY;

endmodule

// File: tb/tb_rr_sched8.sv
// Directed self-checking bench for rr_sched8: reset, fairness rotation,
// back-to-back release, sole holder, pointer wrap and the data path.
module tb_rr_sched8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic [7:0] din;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       out;

   int nAsserts = 0;
   int nFails   = 0;

   rr_sched8 #(.MAX_HOLD(8), .HOLD_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .sel   (sel),
      .busy  (busy),
      .out   (out)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
      req = r;
      din = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(8'h00, 8'h00);
      #1;
      checkOutput("rst_gnt", gnt, 0);
      checkOutput("rst_sel", sel, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out", out, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Fairness: every source owns the line for exactly 8 cycles in turn
      applyStimulus(8'hFF, 8'hFF);
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         for (int c = 0; c < 8; c++) begin
            checkOutput("fair_gnt", gnt, 32'(8'h01 << (i % 8)));
            checkOutput("fair_sel", sel, 32'(i % 8));
            if (c == 0) begin
               checkOutput("fair_busy", busy, 1);
               checkOutput("fair_out", out, 1);
            end
            @(negedge clk);
         end
      end
      checkOutput("owner1_gnt", gnt, 8'h02);

      // Asynchronous reset mid-grant with all requests high
      reset = 1'b1;
      #1;
      checkOutput("midrst_gnt", gnt, 0);
      checkOutput("midrst_sel", sel, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_out", out, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("postrst_gnt", gnt, 8'h01);

      reset = 1'b1;
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Release: source 0 drops after 3 cycles, source 2 takes over on the same edge
      applyStimulus(8'h05, 8'h00);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("rel_gnt0", gnt, 8'h01);
         checkOutput("rel_busy0", busy, 1);
      end
      applyStimulus(8'h04, 8'h00);
      @(negedge clk);
      checkOutput("rel_gnt2", gnt, 8'h04);
      checkOutput("rel_sel2", sel, 2);
      checkOutput("rel_busy2", busy, 1);
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      checkOutput("idle_gnt", gnt, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_sel_hold", sel, 2);
      checkOutput("idle_out", out, 0);

      // Sole holder keeps the grant indefinitely
      applyStimulus(8'h10, 8'h00);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         checkOutput("sole_gnt", gnt, 8'h10);
         checkOutput("sole_sel", sel, 4);
      end
      // Saturated hold plus a competitor: preempt, search starts at 5 and wraps to 0
      applyStimulus(8'h11, 8'h00);
      @(negedge clk);
      checkOutput("preempt_gnt", gnt, 8'h01);
      checkOutput("preempt_sel", sel, 0);
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      checkOutput("preempt_idle", busy, 0);

      // Wrap: pointer 7 favours source 7, then 7 releases to 0
      applyStimulus(8'h40, 8'h00);
      @(negedge clk);
      checkOutput("wrap_gnt6", gnt, 8'h40);
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      applyStimulus(8'h81, 8'h00);
      @(negedge clk);
      checkOutput("wrap_gnt7", gnt, 8'h80);
      checkOutput("wrap_sel7", sel, 7);
      applyStimulus(8'h01, 8'h00);
      @(negedge clk);
      checkOutput("wrap_gnt0", gnt, 8'h01);
      checkOutput("wrap_busy", busy, 1);
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      applyStimulus(8'h80, 8'h00);
      @(negedge clk);
      checkOutput("wrap2_gnt7", gnt, 8'h80);
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);
      applyStimulus(8'h81, 8'h00);
      @(negedge clk);
      checkOutput("wrap2_gnt0", gnt, 8'h01);
      checkOutput("wrap2_sel0", sel, 0);
      applyStimulus(8'h00, 8'h00);
      @(negedge clk);

      // Data path through the mux, gated by busy
      applyStimulus(8'h20, 8'b0010_0000);
      @(negedge clk);
      checkOutput("dp_gnt5", gnt, 8'h20);
      checkOutput("dp_out1", out, 1);
      din = 8'hDF;
      #1;
      checkOutput("dp_out0", out, 0);
      din = 8'hFF;
      #1;
      checkOutput("dp_out1b", out, 1);
      applyStimulus(8'h00, 8'hFF);
      @(negedge clk);
      checkOutput("dp_idle_busy", busy, 0);
      checkOutput("dp_idle_out", out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
